mem_region_ctrl: RTL and testbench
==================================

Name: mem_region_ctrl

Overview:
- Next-generation memory-region unit in the MEM stage, between the load/store decode and the cache/LSU ports.
- Holds a runtime-programmable table of N address regions, each with a cacheable/readable/writeable attribute set and a lock bit.
- Classifies each load/store against the table and routes it through a registered valid/ready stage to the cache or the uncached LSU path.
- Raises an error code with the faulting address for permission violations.

Parameters:
- N_REGIONS, 4, number of table entries (1..16)
- ADDR_W, 32, address width
- RST_START, all 0, per-region reset start address (N_REGIONS x ADDR_W)
- RST_END, all 0, per-region reset end address, exclusive (N_REGIONS x ADDR_W)
- RST_ATTR, all 3'b000, per-region reset attributes: bit0 cacheable, bit1 readable, bit2 writeable

Ports:
- clk  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- load_i  in  1  request is a load
- store_i  in  1  request is a store
- addr_i  in  ADDR_W  request address
- cache_valid_o  out  1  registered request to cache
- cache_ready_i  in  1  cache accepts
- lsu_valid_o  out  1  registered request to uncached LSU
- lsu_ready_i  in  1  LSU accepts
- load_o  out  1  registered load flag (shared by both targets)
- store_o  out  1  registered store flag
- addr_o  out  ADDR_W  registered address
- error_o  out  2  one-cycle error code
- err_addr_o  out  ADDR_W  address of most recent faulting request
- cfg_we_i  in  1  table write strobe
- cfg_idx_i  in  $clog2(N_REGIONS) (min 1)  entry index
- cfg_sel_i  in  2  field select: 0 start, 1 end, 2 attr, 3 lock
- cfg_wdata_i  in  ADDR_W  write data; attr uses [2:0], lock uses [0]

Behaviour:
- Reset (rstn_i low at clk edge):
  - all valid outputs, load_o, store_o, addr_o, error_o, err_addr_o go to 0;
  - table loads RST_* values; all lock bits clear.
- Lookup is combinational on addr_i.
  - Entry i matches iff START[i] <= addr_i < END[i], unsigned.
  - An entry with START >= END never matches.
  - The lowest matching index wins.
- Classification of an accepted request:
  - load_i and store_i both set: error 2'b11, not forwarded.
  - Neither flag set: request is consumed, no output, no error.
  - Matched entry, load without readable: error 2'b01, not forwarded.
  - Matched entry, store without writeable: error 2'b10, not forwarded.
  - Matched entry, permitted, cacheable=1: goes to the cache target.
  - Matched entry, permitted, cacheable=0: goes to the LSU target.
  - No matching entry: goes to the LSU target, no error.
- Output stage is a single register:
  - Latency is 1 cycle from acceptance to cache_valid_o/lsu_valid_o.
  - At most one of cache_valid_o and lsu_valid_o is high.
  - The held request stays stable until the selected target's ready is high.
  - req_ready_o = !out_valid || sel_ready. This is full throughput, with back-to-back acceptance while the target is ready.
- Errors:
  - error_o is registered: it is high exactly 1 cycle after acceptance of the faulting request, otherwise 2'b00.
  - err_addr_o updates on the same edge and holds until the next fault.
  - A faulting request does not occupy the output register.
- Config writes:
  - Take effect at the next clk edge.
  - A lookup in the same cycle uses the old table.
  - A write with lock[idx]=1 is ignored.
  - Writing sel=3 with data[0]=1 sets lock; lock can only be cleared by reset.
- Reset mid-transaction drops the held request; no output is issued after reset.

Decomposition:
- Package mem_region_pkg holds:
  - attr_t as a packed struct {writeable, readable, cacheable};
  - err_e enum (ERR_NONE=0, ERR_RD=1, ERR_WR=2, ERR_BOTH=3);
  - cfg_sel_e enum.
- One sub-module, region_match: combinational priority matcher returning hit and index. The table registers and pipeline stage stay in mem_region_ctrl.

Test Plan:
- Config region0 0x1000..0x2000 attr 3'b111; load 0x1800 -> cache_valid_o=1 next cycle, addr_o=0x1800, error_o=0.
- Load 0x2000, which is an exclusive end with no other match -> lsu_valid_o=1, error_o=0.
- Region1 0x3000..0x4000 attr 3'b011; store 0x3004 -> error_o=2'b10 one cycle, err_addr_o=0x3004, no valid output.
- Hold cache_ready_i=0 for 3 cycles with a request queued -> cache_valid_o stays 1, addr_o stable, req_ready_o=0; next request accepted on the cycle ready rises.
- Overlap region0 0x0..0x8000 uncached and region2 0x1000..0x2000 cacheable; load 0x1500 -> lsu_valid_o=1, showing the lowest index wins.
- Lock region0, then write START=0x5000 -> START stays 0x1000. Assert rstn_i=0 while lsu_valid_o=1 -> all outputs 0 next cycle and lock cleared.

Source files
------------

// File: rtl/mem_region_pkg.sv
// Shared types for the memory-region unit: attribute layout, error codes
// and configuration field selectors.
package mem_region_pkg;

    typedef struct packed {
        logic writeable;
        logic readable;
        logic cacheable;
    } attr_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_RD   = 2'd1,
        ERR_WR   = 2'd2,
        ERR_BOTH = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        SEL_START = 2'd0,
        SEL_END   = 2'd1,
        SEL_ATTR  = 2'd2,
        SEL_LOCK  = 2'd3
    } cfg_sel_e;

    // Index width for an N-entry table, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/region_match.sv
// Combinational priority matcher: finds the lowest-index region whose
// half-open [start, end) range contains the address.
module region_match #(
    parameter int N_REGIONS = 4,
    parameter int ADDR_W    = 32,
    parameter int IDX_W     = 2
) (
    input  logic [ADDR_W-1:0]                 addr_i,
    input  logic [N_REGIONS-1:0][ADDR_W-1:0] start_i,
    input  logic [N_REGIONS-1:0][ADDR_W-1:0] end_i,
    output logic                              hit_o,
    output logic [IDX_W-1:0]                  idx_o
);

    logic [N_REGIONS-1:0] match_s;

    // Per-entry range test; an entry with start >= end can never satisfy both bounds.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            match_s[i] = (start_i[i] <= addr_i) && (addr_i < end_i[i]);
        end
    end

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            idx_o = match_s[i] ? IDX_W'(i) : idx_o;
            hit_o = hit_o | match_s[i];
        end
    end

endmodule

// File: rtl/mem_region_ctrl.sv
// MEM-stage region unit: programmable region table, permission check and a
// single registered valid/ready stage routing to the cache or uncached LSU.
module mem_region_ctrl
    import mem_region_pkg::*;
#(
    parameter int                             N_REGIONS = 4,
    parameter int                             ADDR_W    = 32,
    parameter logic [N_REGIONS-1:0][ADDR_W-1:0] RST_START = '0,
    parameter logic [N_REGIONS-1:0][ADDR_W-1:0] RST_END   = '0,
    parameter logic [N_REGIONS-1:0][2:0]        RST_ATTR  = '0
) (
    input  logic                           clk,
    input  logic                           rstn_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           load_i,
    input  logic                           store_i,
    input  logic [ADDR_W-1:0]              addr_i,
    output logic                           cache_valid_o,
    input  logic                           cache_ready_i,
    output logic                           lsu_valid_o,
    input  logic                           lsu_ready_i,
    output logic                           load_o,
    output logic                           store_o,
    output logic [ADDR_W-1:0]              addr_o,
    output logic [1:0]                     error_o,
    output logic [ADDR_W-1:0]              err_addr_o,
    input  logic                           cfg_we_i,
    input  logic [idx_w(N_REGIONS)-1:0]    cfg_idx_i,
    input  logic [1:0]                     cfg_sel_i,
    input  logic [ADDR_W-1:0]              cfg_wdata_i
);

    localparam int IDX_W = idx_w(N_REGIONS);

    logic [N_REGIONS-1:0][ADDR_W-1:0] start_q;
    logic [N_REGIONS-1:0][ADDR_W-1:0] end_q;
    attr_t [N_REGIONS-1:0]            attr_q;
    logic [N_REGIONS-1:0]             lock_q;

    logic              out_valid_q;
    logic              out_cache_q;
    logic              load_q;
    logic              store_q;
    logic [ADDR_W-1:0] addr_q;
    err_e              error_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic              hit_s;
    logic [IDX_W-1:0]  hit_idx_s;
    attr_t             hit_attr_s;
    logic              sel_ready_s;
    logic              accept_s;
    err_e              err_s;
    logic              fwd_s;
    logic              to_cache_s;
    logic              cfg_wr_ok_s;

    region_match #(
        .N_REGIONS (N_REGIONS),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W)
    ) u_match (
        .addr_i  (addr_i),
        .start_i (start_q),
        .end_i   (end_q),
        .hit_o   (hit_s),
        .idx_o   (hit_idx_s)
    );

    assign hit_attr_s  = attr_q[hit_idx_s];
    assign sel_ready_s = out_cache_q ? cache_ready_i : lsu_ready_i;
    assign req_ready_o = !out_valid_q || sel_ready_s;
    assign accept_s    = req_valid_i && req_ready_o;
    assign cfg_wr_ok_s = cfg_we_i && (int'(cfg_idx_i) < N_REGIONS) && !lock_q[cfg_idx_i];

    // Classify the incoming request against the current (pre-write) table.
    always_comb begin
        err_s      = ERR_NONE;
        fwd_s      = 1'b0;
        to_cache_s = 1'b0;
        if (load_i && store_i) begin
            err_s = ERR_BOTH;
        end else if (!load_i && !store_i) begin
            err_s = ERR_NONE;
        end else if (hit_s && load_i && !hit_attr_s.readable) begin
            err_s = ERR_RD;
        end else if (hit_s && store_i && !hit_attr_s.writeable) begin
            err_s = ERR_WR;
        end else begin
            fwd_s      = 1'b1;
            to_cache_s = hit_s && hit_attr_s.cacheable;
        end
    end

    // Output register and error reporting; faults never occupy the stage.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            out_valid_q <= 1'b0;
            out_cache_q <= 1'b0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            addr_q      <= '0;
            error_q     <= ERR_NONE;
            err_addr_q  <= '0;
        end else begin
            if (accept_s && fwd_s) begin
                out_valid_q <= 1'b1;
                out_cache_q <= to_cache_s;
                load_q      <= load_i;
                store_q     <= store_i;
                addr_q      <= addr_i;
            end else if (sel_ready_s) begin
                out_valid_q <= 1'b0;
            end
            error_q <= accept_s ? err_s : ERR_NONE;
            if (accept_s && (err_s != ERR_NONE)) begin
                err_addr_q <= addr_i;
            end
        end
    end

    // Region table; a locked entry ignores all writes until reset.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            start_q <= RST_START;
            end_q   <= RST_END;
            attr_q  <= RST_ATTR;
            lock_q  <= '0;
        end else if (cfg_wr_ok_s) begin
            case (cfg_sel_e'(cfg_sel_i))
                SEL_START: start_q[cfg_idx_i] <= cfg_wdata_i;
                SEL_END:   end_q[cfg_idx_i]   <= cfg_wdata_i;
                SEL_ATTR:  attr_q[cfg_idx_i]  <= attr_t'(cfg_wdata_i[2:0]);
                SEL_LOCK:  lock_q[cfg_idx_i]  <= lock_q[cfg_idx_i] | cfg_wdata_i[0];
                default:   lock_q[cfg_idx_i]  <= lock_q[cfg_idx_i];
            endcase
        end
    end

    assign cache_valid_o = out_valid_q && out_cache_q;
    assign lsu_valid_o   = out_valid_q && !out_cache_q;
    assign load_o        = load_q;
    assign store_o       = store_q;
    assign addr_o        = addr_q;
    assign error_o       = error_q;
    assign err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the region unit.
module tb_mem_region_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        cache_valid_o;
    logic        cache_ready = 1'b1;
    logic        lsu_valid_o;
    logic        lsu_ready = 1'b1;
    logic        load_o;
    logic        store_o;
    logic [31:0] addr_o;
    logic [1:0]  error_o;
    logic [31:0] err_addr_o;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = 2'd0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [31:0] cfg_wdata = 32'h0;

    int n_chk = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    // model state: table and the single in-flight output
    logic [31:0] m_start [4];
    logic [31:0] m_end   [4];
    logic [2:0]  m_attr  [4];
    logic        m_lock  [4];
    logic        m_valid, m_cache, m_load, m_store;
    logic [31:0] m_addr, m_err_addr;
    logic [1:0]  m_err;

    always #5 clk = ~clk;

    mem_region_ctrl dut (
        .clk           (clk),
        .rstn_i        (rstn),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready_o),
        .load_i        (load),
        .store_i       (store),
        .addr_i        (addr),
        .cache_valid_o (cache_valid_o),
        .cache_ready_i (cache_ready),
        .lsu_valid_o   (lsu_valid_o),
        .lsu_ready_i   (lsu_ready),
        .load_o        (load_o),
        .store_o       (store_o),
        .addr_o        (addr_o),
        .error_o       (error_o),
        .err_addr_o    (err_addr_o),
        .cfg_we_i      (cfg_we),
        .cfg_idx_i     (cfg_idx),
        .cfg_sel_i     (cfg_sel),
        .cfg_wdata_i   (cfg_wdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        logic rdy, acc;
        int   hit;
        logic [2:0] a;
        logic [1:0] e;
        if (!rstn) begin
            for (int i = 0; i < 4; i++) begin
                m_start[i] = 32'h0; m_end[i] = 32'h0; m_attr[i] = 3'b000; m_lock[i] = 1'b0;
            end
            m_valid = 1'b0; m_cache = 1'b0; m_load = 1'b0; m_store = 1'b0;
            m_addr = 32'h0; m_err = 2'b00; m_err_addr = 32'h0;
            return;
        end
        rdy = !m_valid || (m_cache ? cache_ready : lsu_ready);
        acc = req_valid && rdy;
        if (m_valid && rdy) m_valid = 1'b0;
        m_err = 2'b00;
        if (acc) begin
            hit = -1;
            for (int i = 0; i < 4; i++)
                if (hit < 0 && m_start[i] <= addr && addr < m_end[i]) hit = i;
            a = (hit >= 0) ? m_attr[hit] : 3'b000;
            if (load && store)                  e = 2'b11;
            else if (!load && !store)           e = 2'b00;
            else if (hit >= 0 && load && !a[1]) e = 2'b01;
            else if (hit >= 0 && store && !a[2]) e = 2'b10;
            else                                e = 2'b00;
            if (e != 2'b00) begin
                m_err = e;
                m_err_addr = addr;
            end else if (load ^ store) begin
                m_valid = 1'b1;
                m_cache = (hit >= 0) && a[0];
                m_load = load; m_store = store; m_addr = addr;
            end
        end
        if (cfg_we && !m_lock[cfg_idx]) begin
            if (cfg_sel == 2'd0)      m_start[cfg_idx] = cfg_wdata;
            else if (cfg_sel == 2'd1) m_end[cfg_idx]   = cfg_wdata;
            else if (cfg_sel == 2'd2) m_attr[cfg_idx]  = cfg_wdata[2:0];
            else if (cfg_wdata[0])    m_lock[cfg_idx]  = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic cfg(input logic [1:0] idx, input logic [1:0] sel, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic req(input logic ld, input logic st, input logic [31:0] a);
        req_valid = 1'b1; load = ld; store = st; addr = a;
        tick();
        req_valid = 1'b0;
    endtask

    // Compare every DUT output against the model on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("req_ready", {31'b0, req_ready_o},
                {31'b0, !m_valid || (m_cache ? cache_ready : lsu_ready)});
            chk("cache_valid", {31'b0, cache_valid_o}, {31'b0, m_valid && m_cache});
            chk("lsu_valid", {31'b0, lsu_valid_o}, {31'b0, m_valid && !m_cache});
            chk("error", {30'b0, error_o}, {30'b0, m_err});
            chk("err_addr", err_addr_o, m_err_addr);
            if (m_valid) begin
                chk("addr_o", addr_o, m_addr);
                chk("load_o", {31'b0, load_o}, {31'b0, m_load});
                chk("store_o", {31'b0, store_o}, {31'b0, m_store});
            end
        end
    end

    initial begin
        int r;
        tick();
        check_en = 1'b1;
        tick();
        @(negedge clk);
        chk("lit_rst_valid", {30'b0, cache_valid_o, lsu_valid_o}, 32'h0);
        chk("lit_rst_err", {30'b0, error_o}, 32'h0);
        chk("lit_rst_addr", addr_o | err_addr_o, 32'h0);
        rstn = 1'b1;

        // cacheable region hit
        cfg(2'd0, 2'd0, 32'h1000); cfg(2'd0, 2'd1, 32'h2000); cfg(2'd0, 2'd2, 32'h7);
        req(1'b1, 1'b0, 32'h1800);
        @(negedge clk);
        chk("lit_cache_hit", {31'b0, cache_valid_o}, 32'h1);
        chk("lit_cache_addr", addr_o, 32'h1800);
        chk("lit_cache_err", {30'b0, error_o}, 32'h0);

        // exclusive end falls through to LSU
        req(1'b1, 1'b0, 32'h2000);
        @(negedge clk);
        chk("lit_end_lsu", {31'b0, lsu_valid_o}, 32'h1);
        chk("lit_end_err", {30'b0, error_o}, 32'h0);

        // store to non-writeable region
        cfg(2'd1, 2'd0, 32'h3000); cfg(2'd1, 2'd1, 32'h4000); cfg(2'd1, 2'd2, 32'h3);
        req(1'b0, 1'b1, 32'h3004);
        @(negedge clk);
        chk("lit_wr_err", {30'b0, error_o}, 32'h2);
        chk("lit_wr_eaddr", err_addr_o, 32'h3004);
        chk("lit_wr_novalid", {30'b0, cache_valid_o, lsu_valid_o}, 32'h0);
        tick();
        @(negedge clk);
        chk("lit_err_1cyc", {30'b0, error_o}, 32'h0);

        // backpressure from the cache
        cache_ready = 1'b0;
        req(1'b1, 1'b0, 32'h1800);
        req_valid = 1'b1; load = 1'b1; store = 1'b0; addr = 32'h1900;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lit_hold_valid", {31'b0, cache_valid_o}, 32'h1);
            chk("lit_hold_addr", addr_o, 32'h1800);
            chk("lit_hold_rdy", {31'b0, req_ready_o}, 32'h0);
            tick();
        end
        cache_ready = 1'b1;
        @(negedge clk);
        chk("lit_release_rdy", {31'b0, req_ready_o}, 32'h1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("lit_next_addr", addr_o, 32'h1900);
        tick();

        // overlap: lowest index (uncached) wins
        cfg(2'd0, 2'd0, 32'h0); cfg(2'd0, 2'd1, 32'h8000); cfg(2'd0, 2'd2, 32'h2);
        cfg(2'd2, 2'd0, 32'h1000); cfg(2'd2, 2'd1, 32'h2000); cfg(2'd2, 2'd2, 32'h7);
        req(1'b1, 1'b0, 32'h1500);
        @(negedge clk);
        chk("lit_overlap_lsu", {30'b0, cache_valid_o, lsu_valid_o}, 32'h1);

        // lock freezes region0
        cfg(2'd0, 2'd0, 32'h1000); cfg(2'd0, 2'd1, 32'h2000); cfg(2'd0, 2'd2, 32'h7);
        cfg(2'd0, 2'd3, 32'h1);
        cfg(2'd0, 2'd0, 32'h5000);
        req(1'b1, 1'b0, 32'h1800);
        @(negedge clk);
        chk("lit_lock_cache", {30'b0, cache_valid_o, lsu_valid_o}, 32'h2);

        // reset while a request is held
        lsu_ready = 1'b0;
        req(1'b1, 1'b0, 32'h9000);
        @(negedge clk);
        chk("lit_pre_rst_lsu", {31'b0, lsu_valid_o}, 32'h1);
        rstn = 1'b0;
        tick();
        @(negedge clk);
        chk("lit_rst_drop", {28'b0, cache_valid_o, lsu_valid_o, error_o}, 32'h0);
        chk("lit_rst_addr2", addr_o, 32'h0);
        rstn = 1'b1; lsu_ready = 1'b1;
        cfg(2'd0, 2'd0, 32'h100); cfg(2'd0, 2'd1, 32'h200); cfg(2'd0, 2'd2, 32'h3);
        req(1'b1, 1'b0, 32'h150);
        @(negedge clk);
        chk("lit_unlock_cache", {31'b0, cache_valid_o}, 32'h1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(0, 399) != 0);
            req_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 15));
            load  = (r < 7) || (r == 15);
            store = (r >= 7 && r < 14) || (r == 15);
            addr = 32'($urandom_range(0, 32'hFFFF));
            cache_ready = ($urandom_range(0, 3) != 0);
            lsu_ready   = ($urandom_range(0, 3) != 0);
            cfg_we  = ($urandom_range(0, 5) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_sel = 2'($urandom_range(0, 3));
            if (cfg_sel == 2'd3)      cfg_wdata = {31'b0, ($urandom_range(0, 11) == 0)};
            else if (cfg_sel == 2'd2) cfg_wdata = 32'($urandom_range(0, 7));
            else                      cfg_wdata = 32'($urandom_range(0, 32'hFFFF));
            tick();
        end
        req_valid = 1'b0; cfg_we = 1'b0; rstn = 1'b1;
        tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
